// File: rtl/sram_like_bridge_if.sv
// ============================================================================
//  Module   : sram_like_bridge_if
//  Brief    : Request/response memory bus between the SRAM-like bridge and
//             the bus slave. Supports at most one outstanding transaction.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_wr;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    // Bridge side: issues requests, receives handshakes and read data
    modport master (
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    // Memory side: accepts requests, returns handshakes and read data
    modport slave (
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/sram_like_bridge.sv
// ============================================================================
//  Module   : sram_like_bridge
//  Brief    : Serialises the core's instruction and data SRAM ports onto one
//             request/response bus (one outstanding transaction, data port
//             first) and stalls the pipeline until every enabled port has
//             its response. Read data is held in per-port registers.
//  Options  : `SRAM_BRIDGE_ADDR_MAP_EN - fold kseg0/kseg1 addresses
//             (0x8000_0000-0xBFFF_FFFF) down to physical (addr & 0x1FFF_FFFF).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,               // asynchronous, active-low

    input  logic                 inst_sram_en,
    input  logic [DATA_W/8-1:0]  inst_sram_wen,
    input  logic [ADDR_W-1:0]    inst_sram_addr,
    input  logic [DATA_W-1:0]    inst_sram_wdata,
    output logic [DATA_W-1:0]    inst_sram_rdata,

    input  logic                 data_sram_en,
    input  logic [DATA_W/8-1:0]  data_sram_wen,
    input  logic [ADDR_W-1:0]    data_sram_addr,
    input  logic [DATA_W-1:0]    data_sram_wdata,
    output logic [DATA_W-1:0]    data_sram_rdata,

    output logic                 stallreq_for_bus,

    sram_like_bridge_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_ADDR = 3'd1,
        ST_D_WAIT = 3'd2,
        ST_I_ADDR = 3'd3,
        ST_I_WAIT = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_d_done;
    logic                 r_i_done;
    logic [DATA_W-1:0]    r_inst_rdata;
    logic [DATA_W-1:0]    r_data_rdata;

    logic                 w_d_pend;
    logic                 w_i_pend;
    logic [ADDR_W-1:0]    w_inst_addr_bus;
    logic [ADDR_W-1:0]    w_data_addr_bus;

    // Virtual-to-bus address translation applied to both ports
    function automatic logic [ADDR_W-1:0] f_bus_addr(input logic [ADDR_W-1:0] a);
`ifdef SRAM_BRIDGE_ADDR_MAP_EN
        // kseg0/kseg1 have top bits 2'b10; strip the top three bits there
        if (a[ADDR_W-1 -: 2] == 2'b10) begin
            f_bus_addr = {3'b000, a[ADDR_W-4:0]};
        end else begin
            f_bus_addr = a;
        end
`else
        f_bus_addr = a;
`endif
    endfunction

    assign w_inst_addr_bus = f_bus_addr(inst_sram_addr);
    assign w_data_addr_bus = f_bus_addr(data_sram_addr);

    // A port still needs the bus while it is enabled and has no response yet
    assign w_d_pend         = data_sram_en & ~r_d_done;
    assign w_i_pend         = inst_sram_en & ~r_i_done;
    assign stallreq_for_bus = w_d_pend | w_i_pend;

    assign inst_sram_rdata  = r_inst_rdata;
    assign data_sram_rdata  = r_data_rdata;

    // Bus request fields come straight from the held port during ADDR states
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_wstrb = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            ST_D_ADDR: begin
                bus.mem_req   = 1'b1;
                bus.mem_wr    = |data_sram_wen;
                bus.mem_wstrb = data_sram_wen;
                bus.mem_addr  = w_data_addr_bus;
                bus.mem_wdata = data_sram_wdata;
            end
            ST_I_ADDR: begin
                bus.mem_req   = 1'b1;
                bus.mem_wr    = |inst_sram_wen;
                bus.mem_wstrb = inst_sram_wen;
                bus.mem_addr  = w_inst_addr_bus;
                bus.mem_wdata = inst_sram_wdata;
            end
            default: ;
        endcase
    end

    // Transaction sequencer: state, per-port done flags and read-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_d_done     <= 1'b0;
            r_i_done     <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_d_pend) begin
                        r_state <= ST_D_ADDR;
                    end else if (w_i_pend) begin
                        r_state <= ST_I_ADDR;
                    end
                end
                ST_D_ADDR: begin
                    if (bus.mem_addr_ok) begin
                        r_state <= ST_D_WAIT;
                    end
                end
                ST_D_WAIT: begin
                    if (bus.mem_data_ok) begin
                        r_data_rdata <= bus.mem_rdata;
                        r_d_done     <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_I_ADDR: begin
                    if (bus.mem_addr_ok) begin
                        r_state <= ST_I_WAIT;
                    end
                end
                ST_I_WAIT: begin
                    if (bus.mem_data_ok) begin
                        r_inst_rdata <= bus.mem_rdata;
                        r_i_done     <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Once the stall drops the core advances; the held requests are
            // consumed, so the flags must not leak into the next request
            if (!stallreq_for_bus) begin
                r_d_done <= 1'b0;
                r_i_done <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
